// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction fetch
// and the MEM stage. One outstanding transaction at a time, and data wins
// whenever both requesters are seen together in IDLE. A redirect (flush_i)
// cancels an in-flight fetch: the bus access still completes, but its data
// is discarded and no if_done_o pulse is produced.
//
// Optional build macro MEM_ARB_PERF_EN adds two saturating 32-bit stall
// cycle counters (perf_if_stall_o, perf_dm_stall_o).
//
// state | meaning
// IDLE  | no transaction; sample requesters (data first)
// REQ   | mem_req_o high with stable address/controls, waiting for mem_gnt_i
// RSP   | granted, waiting for mem_rvalid_i
// DONE  | owner's done pulse is visible this cycle; return to IDLE

module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic [DATA_W-1:0]   if_rdata_o,
   output logic                if_done_o,
   input  logic                dm_req_i,
   input  logic                dm_we_i,
   input  logic [ADDR_W-1:0]   dm_addr_i,
   input  logic [DATA_W-1:0]   dm_wdata_i,
   input  logic [DATA_W/8-1:0] dm_wstrb_i,
   output logic [DATA_W-1:0]   dm_rdata_o,
   output logic                dm_done_o,
   input  logic                flush_i,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_wstrb_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   output logic                stall_if_o,
   output logic                stall_mem_o
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]         perf_if_stall_o,
   output logic [31:0]         perf_dm_stall_o
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;
   logic   owner;   // 0 = fetch, 1 = data
   logic   cancel;
   logic   fetch_drop;

   // A fetch in flight is abandoned by a redirect or by IF letting go of its
   // request; either one means the returning instruction must be dropped.
   assign fetch_drop = !owner & (flush_i | !if_req_i);

   // Stall requests fed into the hazard unit's stall/flush network.
   assign stall_mem_o = dm_req_i & !dm_done_o;
   assign stall_if_o  = if_req_i & !if_done_o & !flush_i;

   // Transaction sequencer with registered memory-side and requester outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= 1'b0;
         cancel      <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_wstrb_o <= '0;
         if_rdata_o  <= '0;
         if_done_o   <= 1'b0;
         dm_rdata_o  <= '0;
         dm_done_o   <= 1'b0;
      end else begin
         if_done_o <= 1'b0;
         dm_done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (dm_req_i) begin
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= dm_we_i;
                  mem_addr_o  <= dm_addr_i;
                  mem_wdata_o <= dm_wdata_i;
                  mem_wstrb_o <= dm_wstrb_i;
                  owner       <= 1'b1;
                  state       <= REQ;
               end else if (if_req_i && !flush_i) begin
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= if_addr_i;
                  mem_wdata_o <= '0;
                  mem_wstrb_o <= '0;
                  owner       <= 1'b0;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (fetch_drop) cancel <= 1'b1;
               if (mem_gnt_i) begin
                  mem_req_o <= 1'b0;
                  state     <= RSP;
               end
            end
            RSP: begin
               if (fetch_drop) cancel <= 1'b1;
               if (mem_rvalid_i) begin
                  state <= DONE;
                  if (owner) begin
                     dm_done_o <= 1'b1;
                     if (!mem_we_o) dm_rdata_o <= mem_rdata_i;
                  end else if (!(cancel || fetch_drop)) begin
                     if_done_o  <= 1'b1;
                     if_rdata_o <= mem_rdata_i;
                  end
               end
            end
            DONE: begin
               // Requests still high here belong to the access just finished.
               cancel <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_PERF_EN
   // Saturating stall-cycle counters for performance analysis.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_if_stall_o <= '0;
         perf_dm_stall_o <= '0;
      end else begin
         if (stall_if_o && (perf_if_stall_o != '1))
            perf_if_stall_o <= perf_if_stall_o + 32'd1;
         if (stall_mem_o && (perf_dm_stall_o != '1))
            perf_dm_stall_o <= perf_dm_stall_o + 32'd1;
      end
   end
`endif

endmodule
